// File: rtl/dsp_mac_pipe.sv
// Four-stage pre-add / multiply / post-add slice with runtime opmode, accumulate and carry/borrow out.
// opmode bits: [0] pre_sub, [1] use_pre, [2] post_sub, [3] accum.
module dsp_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int BD_WIDTH = 18,
    parameter int P_WIDTH  = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [A_WIDTH-1:0]  A,
    input  logic [BD_WIDTH-1:0] B,
    input  logic [BD_WIDTH-1:0] D,
    input  logic [P_WIDTH-1:0]  C,
    input  logic [3:0]          opmode,
    output logic [P_WIDTH-1:0]  P,
    output logic                carry_out,
    output logic                out_valid
);

    generate
        if (P_WIDTH < A_WIDTH + BD_WIDTH) begin : g_width_chk
            $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH + BD_WIDTH");
        end
    endgenerate

    // Valid semantics: in_valid qualifies one sample per cycle with no backpressure;
    // out_valid is high for exactly the cycle in which P/carry_out took that sample's result.

    logic [A_WIDTH-1:0]          a1_q, a2_q;
    logic [BD_WIDTH-1:0]         b1_q, d1_q, pre2_q;
    logic [P_WIDTH-1:0]          c1_q, c2_q, c3_q, m3_q, p_q;
    logic [3:0]                  op1_q, op2_q, op3_q;
    logic                        v1_q, v2_q, v3_q, ov_q, co_q;

    logic [BD_WIDTH-1:0]         pre_d;
    logic [A_WIDTH+BD_WIDTH-1:0] m_full;
    logic [P_WIDTH-1:0]          m_d;
    logic [P_WIDTH-1:0]          z;
    logic [P_WIDTH:0]            r_d;

    always_comb begin
        pre_d  = b1_q;
        if (op1_q[1]) begin
            pre_d = op1_q[0] ? (d1_q - b1_q) : (d1_q + b1_q);
        end
        m_full = a2_q * pre2_q;
        m_d    = P_WIDTH'(m_full);
        // Accumulate uses the P register as it stands before this cycle's update.
        z      = op3_q[3] ? p_q : c3_q;
        r_d    = op3_q[2] ? ({1'b0, z} - {1'b0, m3_q}) : ({1'b0, z} + {1'b0, m3_q});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a1_q   <= '0;
            b1_q   <= '0;
            d1_q   <= '0;
            c1_q   <= '0;
            op1_q  <= '0;
            v1_q   <= 1'b0;
            pre2_q <= '0;
            a2_q   <= '0;
            c2_q   <= '0;
            op2_q  <= '0;
            v2_q   <= 1'b0;
            m3_q   <= '0;
            c3_q   <= '0;
            op3_q  <= '0;
            v3_q   <= 1'b0;
            p_q    <= '0;
            co_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            a1_q   <= A;
            b1_q   <= B;
            d1_q   <= D;
            c1_q   <= C;
            op1_q  <= opmode;
            v1_q   <= in_valid;
            pre2_q <= pre_d;
            a2_q   <= a1_q;
            c2_q   <= c1_q;
            op2_q  <= op1_q;
            v2_q   <= v1_q;
            m3_q   <= m_d;
            c3_q   <= c2_q;
            op3_q  <= op2_q;
            v3_q   <= v2_q;
            ov_q   <= v3_q;
            if (v3_q) begin
                p_q  <= r_d[P_WIDTH-1:0];
                co_q <= r_d[P_WIDTH];
            end
        end
    end

    assign P         = p_q;
    assign carry_out = co_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: directed steps plus a few random samples, scoreboard keyed on arrival edge.
module tb_dsp_mac_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [17:0] a = '0, b = '0, d = '0;
    logic [47:0] c = '0;
    logic [3:0]  op = '0;
    logic [47:0] p;
    logic        co, ov;

    logic        s_valid = 1'b0;
    logic [7:0]  s_a = '0, s_b = '0, s_d = '0;
    logic [15:0] s_c = '0;
    logic [3:0]  s_op = '0;
    logic [15:0] s_p;
    logic        s_co, s_ov;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [48:0] exp_q[$];
    int          due_q[$];
    logic [47:0] model_p = '0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    dsp_mac_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(a), .B(b), .D(d), .C(c), .opmode(op),
        .P(p), .carry_out(co), .out_valid(ov)
    );

    dsp_mac_pipe #(.A_WIDTH(8), .BD_WIDTH(8), .P_WIDTH(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid),
        .A(s_a), .B(s_b), .D(s_d), .C(s_c), .opmode(s_op),
        .P(s_p), .carry_out(s_co), .out_valid(s_ov)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [48:0] model(input logic [17:0] ma, mb, md, input logic [47:0] mc,
                                          input logic [3:0] mop, input logic [47:0] pprev);
        logic [17:0] pre;
        logic [47:0] ax, px, m, zz;
        pre = mb;
        if (mop[1]) pre = mop[0] ? (md - mb) : (md + mb);
        ax = {30'd0, ma};
        px = {30'd0, pre};
        m  = ax * px;
        zz = mop[3] ? pprev : mc;
        return mop[2] ? ({1'b0, zz} - {1'b0, m}) : ({1'b0, zz} + {1'b0, m});
    endfunction

    // Drives one valid sample for the edge after the call; expected {carry, P} is queued.
    task automatic send(input logic [17:0] ta, tb, td, input logic [47:0] tc,
                        input logic [3:0] top, input logic [48:0] expv);
        a = ta; b = tb; d = td; c = tc; op = top;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        due_q.push_back(edge_n + 4);
        model_p = expv[47:0];
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [17:0] ra, rb, rd;
        logic [63:0] rc;
        logic [3:0]  rop;
        ra  = 18'($urandom_range(0, 262143));
        rb  = 18'($urandom_range(0, 262143));
        rd  = 18'($urandom_range(0, 262143));
        rc  = {$urandom, $urandom};
        rop = 4'($urandom_range(0, 15));
        send(ra, rb, rd, rc[47:0], rop, model(ra, rb, rd, rc[47:0], rop, model_p));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (ov === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed out_valid at edge %0d expected none", edge_n);
            end
            if (exp_q.size() > 0) begin
                logic [48:0] e;
                int          du;
                e  = exp_q.pop_front();
                du = due_q.pop_front();
                n_checks++;
                assert ({co, p} === e) else begin
                    n_fail++;
                    $error("FAIL result: observed %0h expected %0h", {co, p}, e);
                end
                n_checks++;
                assert (edge_n === du) else begin
                    n_fail++;
                    $error("FAIL latency: observed edge %0d expected edge %0d", edge_n, du);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_p", 64'(p), 64'd0);
        check("rst_co", 64'(co), 64'd0);
        check("rst_ov", 64'(ov), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD baseline, then P must hold with out_valid low
        send(18'd10, 18'd5, 18'd7, 48'd20, 4'b0010, {1'b0, 48'd140});
        drain();
        check("add_hold_p", 64'(p), 64'd140);
        check("add_ov_once", 64'(ov), 64'd0);

        send(18'd10, 18'd5, 18'd7, 48'd20, 4'b0011, {1'b0, 48'd40});
        send(18'd10, 18'd5, 18'd7, 48'd20, 4'b0000, {1'b0, 48'd70});
        send(18'd6, 18'd20, 18'd15, 48'd100, 4'b0110, {1'b1, 48'hFFFF_FFFF_FF92});
        drain();

        // Accumulate chain from a fresh reset, with a bubble before the last step
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_p = '0;
        send(18'd2, 18'd1, 18'd2, 48'd0, 4'b1010, {1'b0, 48'd6});
        send(18'd2, 18'd1, 18'd2, 48'd0, 4'b1010, {1'b0, 48'd12});
        send(18'd2, 18'd1, 18'd2, 48'd0, 4'b1010, {1'b0, 48'd18});
        send(18'd2, 18'd1, 18'd2, 48'd0, 4'b1010, {1'b0, 48'd24});
        @(posedge clk);
        #1;
        send(18'd2, 18'd1, 18'd2, 48'd0, 4'b1010, {1'b0, 48'd30});
        drain();

        // Reset two cycles after an accepted sample discards it
        send(18'd10, 18'd5, 18'd7, 48'd20, 4'b0010, {1'b0, 48'd140});
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_p = '0;
        @(negedge clk);
        check("midrst_p", 64'(p), 64'd0);
        check("midrst_ov", 64'(ov), 64'd0);
        send(18'd10, 18'd5, 18'd7, 48'd20, 4'b0010, {1'b0, 48'd140});
        drain();

        for (int i = 0; i < 8; i++) send_rand();
        drain();

        // Narrow instance: pre-add wrap, then post-add wrap with carry
        s_a = 8'd255; s_b = 8'd255; s_d = 8'd1; s_c = 16'd5; s_op = 4'b0010;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("narrow1_ov", 64'(s_ov), 64'd1);
        check("narrow1_p", 64'(s_p), 64'd5);
        check("narrow1_co", 64'(s_co), 64'd0);
        s_a = 8'd255; s_b = 8'd0; s_d = 8'd255; s_c = 16'hFFFF; s_op = 4'b0010;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("narrow2_ov", 64'(s_ov), 64'd1);
        check("narrow2_p", 64'(s_p), 64'hFE00);
        check("narrow2_co", 64'(s_co), 64'd1);
        @(negedge clk);
        check("narrow2_ov_drop", 64'(s_ov), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised successor to the team's simplified DSP48A1 slice. Computes a pre-add/multiply/post-add over operands A, B, D and C, with widths as parameters. The operation is selected per sample by a runtime `opmode` instead of a fixed build parameter. Adds a fixed 4-stage pipeline with valid tracking, an accumulate mode and a carry/borrow flag. It sits in the datapath wherever the earlier single-operation slice was used.

## Interface
- `A_WIDTH`, 18, width of multiplier operand A
- `BD_WIDTH`, 18, width of B, D and the pre-adder result
- `P_WIDTH`, 48, width of C and P; must be ≥ A_WIDTH+BD_WIDTH (elaboration error otherwise)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `in_valid`  in  1  sample on A/B/D/C/opmode is valid this cycle
- `A`  in  A_WIDTH  unsigned multiplier operand
- `B`  in  BD_WIDTH  unsigned pre-adder operand
- `D`  in  BD_WIDTH  unsigned pre-adder operand
- `C`  in  P_WIDTH  unsigned post-adder operand
- `opmode`  in  4  [0] pre_sub, [1] use_pre, [2] post_sub, [3] accum
- `P`  out  P_WIDTH  result register
- `carry_out`  out  1  carry (add) or borrow (sub) out of the post-adder
- `out_valid`  out  1  P/carry_out were updated this cycle

## Operation
- Unsigned arithmetic throughout; all results are modulo 2^width of their stage.
- Stage 1 registers A, B, D, C, opmode and in_valid.
- Stage 2 computes the pre-adder:
  - PRE = D−B if pre_sub, else D+B, truncated to BD_WIDTH.
  - If use_pre=0, PRE = B and pre_sub is ignored.
  - Registers PRE, A, C, opmode and valid.
- Stage 3 computes M = A×PRE (A_WIDTH+BD_WIDTH bits), zero-extended to P_WIDTH. Registers M, C, opmode and valid.
- Stage 4, post-adder:
  - Z = current P if accum, else C.
  - R = Z+M if post_sub=0, else Z−M, computed on P_WIDTH+1 bits.
  - P ← R[P_WIDTH−1:0].
  - carry_out ← R[P_WIDTH]: carry for add, borrow (M>Z) for sub.
- Stage 4 updates only when its valid bit is 1. Otherwise P and carry_out hold.
- out_valid = the stage-4 valid, registered together with P (high in the same cycle P changes).
- Accumulate reads the P register value before this cycle's update. Back-to-back accumulate samples therefore chain with no hazard.
- Stages 1-3 advance every cycle. There is no stall and no backpressure: one sample per cycle maximum.
- Reset (rst_n=0 at a rising edge) clears every pipeline register, valid bit, P, carry_out and out_valid to 0. In-flight samples are discarded. Reset dominates in_valid.

## Timing
- Latency 4 cycles: a sample accepted at edge k (in_valid=1) produces P, carry_out and out_valid=1 after edge k+3.
- Throughput 1 sample/cycle. Any in_valid pattern is preserved with the same spacing on out_valid.
- After rst_n returns high, a sample can be accepted at the very next edge.
- Reset values: P=0, carry_out=0, out_valid=0.

## Test plan
- ADD baseline: A=10, B=5, D=7, C=20, opmode=0b0010, one valid pulse -> after 4 edges P=140, carry_out=0, out_valid=1 for exactly 1 cycle; P holds 140 afterwards.
- Pre-sub and bypass:
  - A=10, B=5, D=7, C=20, opmode=0b0011 -> P=40.
  - Same operands with opmode=0b0000 (bypass) -> P=70.
- Post-sub borrow: A=6, B=20, D=15, C=100, opmode=0b0110 -> P=2^48−110, carry_out=1.
- Accumulate chain:
  - Reset, then 3 consecutive valid samples A=2, B=1, D=2, opmode=0b1010 -> P=6, 12, 18 on 3 consecutive out_valid cycles.
  - A bubble (in_valid=0) inserted mid-chain delays the next step by one cycle without changing the sums.
- Reset mid-operation: issue the ADD baseline, assert rst_n=0 for one edge 2 cycles later -> P=0, out_valid never pulses for that sample. A new sample right after reset completes normally with 4-cycle latency.
- Width parameter: instance with A_WIDTH=8, BD_WIDTH=8, P_WIDTH=16; A=255, B=255, D=1 (pre-add wraps to 0) with C=5, opmode=0b0010 -> P=5. The same instance with A=255, D=255, B=0, C=0xFFFF -> P wraps to 0xFE00, carry_out=1.
